// File: rtl/aes_out_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aes_out_buffer
//  Purpose  : Credit-based issue control and in-order output FIFO for a
//             fixed-latency, non-stallable AES core. An issue is admitted
//             only while outstanding blocks (in flight plus buffered) are
//             fewer than DEPTH, so every result always has a FIFO slot.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_out_buffer #(
  parameter int LATENCY = 21,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   core_issue,
  input  logic [127:0]           core_out,
  output logic                   out_valid,
  output logic [127:0]           out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   ovf_err
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0]   C_LAST  = PW'(DEPTH - 1);

  logic [LATENCY-1:0] tracker_q, tracker_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic [127:0]       mem_q [DEPTH];

  logic capture;
  logic pop;
  logic full;
  logic wr_en;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit check uses only registered state, so it never depends on the
  // same-edge capture or pop.
  assign occupancy  = inflight_q + count_q;
  assign in_ready   = (occupancy < C_DEPTH);
  assign core_issue = in_valid & in_ready;

  // The oldest tracker bit marks the edge on which core_out holds a result.
  assign capture   = tracker_q[LATENCY-1];
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;
  assign full      = (count_q == C_DEPTH);
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign wr_en     = capture & (~full | pop);
  assign ovf_err   = ovf_q;

  generate
    if (LATENCY == 1) begin : g_trk_single
      assign tracker_d = core_issue;
    end else begin : g_trk_shift
      assign tracker_d = {tracker_q[LATENCY-2:0], core_issue};
    end
  endgenerate

  // Next-state for the counters, pointers and sticky overflow flag.
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;

    // A dropped capture still retires its in-flight slot; the zero guard
    // keeps the count sane if the tracker ever fires without an issue.
    if (core_issue && !capture) begin
      inflight_d = inflight_q + CW'(1);
    end else if (capture && !core_issue && (inflight_q != '0)) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CW'(1);
    end

    if (wr_en) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    if (capture && !wr_en) begin
      ovf_d = 1'b1;
    end
  end

  // Control state; clearing the tracker discards every block still in the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tracker_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tracker_q  <= tracker_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Data storage is left unreset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= core_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_out_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_aes_out_buffer
//  Purpose  : Self-checking bench for aes_out_buffer (LATENCY=21, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_out_buffer;

  localparam int LATENCY = 21;
  localparam int DEPTH   = 4;

  localparam logic [127:0] C_V0  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_D0  = 128'h00000000_11111111_22222222_33333333;
  localparam logic [127:0] C_D1  = 128'h44444444_55555555_66666666_77777777;
  localparam logic [127:0] C_D2  = 128'h88888888_99999999_aaaaaaaa_bbbbbbbb;
  localparam logic [127:0] C_D3  = 128'hcccccccc_dddddddd_eeeeeeee_ffffffff;
  localparam logic [127:0] C_D4  = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] C_BAD = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         core_issue;
  logic [127:0] core_out;
  logic [127:0] core_out_tbl = '0;
  logic         stream_mode = 1'b0;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready = 1'b0;
  logic [2:0]   occupancy;
  logic         ovf_err;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  aes_out_buffer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .core_issue (core_issue),
    .core_out   (core_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen by the DUT at an edge is the number of earlier edges.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] f(input int c);
    logic [31:0] w;
    w = c[31:0] ^ 32'hC0DE0000;
    return {w, w, w, w};
  endfunction

  assign core_out = stream_mode ? f(cyc) : core_out_tbl;

  typedef struct {
    int           n;
    logic         iv;
    logic         ordy;
    logic [127:0] cd;
    logic         e_ir;
    logic         e_ov;
    logic [2:0]   e_occ;
    logic         chk_d;
    logic [127:0] e_d;
    logic         e_ovf;
  } vec_t;

  function automatic vec_t mk(input int n, input logic iv, input logic ordy,
                              input logic [127:0] cd, input logic e_ir,
                              input logic e_ov, input logic [2:0] e_occ,
                              input logic chk_d, input logic [127:0] e_d,
                              input logic e_ovf);
    vec_t v;
    v.n = n; v.iv = iv; v.ordy = ordy; v.cd = cd; v.e_ir = e_ir;
    v.e_ov = e_ov; v.e_occ = e_occ; v.chk_d = chk_d; v.e_d = e_d; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input logic eir, input logic eov,
                            input logic [2:0] eocc, input logic eovf);
    check({nm, " {in_ready,out_valid,occ,ovf}"},
          128'({in_ready, out_valid, occupancy, ovf_err}),
          128'({eir, eov, eocc, eovf}));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, issued, popped, seen;
    logic will_issue;

    // ---------------- directed table ----------------
    // Single issue, result at edge 21, popped at edge 22.
    vecs[0]  = mk(1,  1, 1, '0,    1, 0, 3'd1, 0, '0,   0);
    vecs[1]  = mk(20, 0, 1, '0,    1, 0, 3'd1, 0, '0,   0);
    vecs[2]  = mk(1,  0, 1, C_V0,  1, 1, 3'd1, 1, C_V0, 0);
    vecs[3]  = mk(1,  0, 1, '0,    1, 0, 3'd0, 0, '0,   0);
    // Four back-to-back issues with the consumer stalled.
    vecs[4]  = mk(4,  1, 0, '0,    0, 0, 3'd4, 0, '0,   0);
    vecs[5]  = mk(17, 0, 0, '0,    0, 0, 3'd4, 0, '0,   0);
    vecs[6]  = mk(1,  0, 0, C_D0,  0, 1, 3'd4, 1, C_D0, 0);
    vecs[7]  = mk(1,  0, 0, C_D1,  0, 1, 3'd4, 1, C_D0, 0);
    vecs[8]  = mk(1,  0, 0, C_D2,  0, 1, 3'd4, 1, C_D0, 0);
    vecs[9]  = mk(1,  0, 0, C_D3,  0, 1, 3'd4, 1, C_D0, 0);
    vecs[10] = mk(3,  0, 0, '0,    0, 1, 3'd4, 1, C_D0, 0);
    // Full FIFO: pop with in_valid held; credit is from pre-edge occupancy.
    vecs[11] = mk(1,  1, 1, '0,    1, 1, 3'd3, 1, C_D1, 0);
    vecs[12] = mk(1,  1, 0, '0,    0, 1, 3'd4, 1, C_D1, 0);
    vecs[13] = mk(20, 0, 0, '0,    0, 1, 3'd4, 1, C_D1, 0);
    vecs[14] = mk(1,  0, 0, C_D4,  0, 1, 3'd4, 1, C_D1, 0);
    vecs[15] = mk(1,  0, 1, '0,    1, 1, 3'd3, 1, C_D2, 0);
    vecs[16] = mk(1,  0, 1, '0,    1, 1, 3'd2, 1, C_D3, 0);
    vecs[17] = mk(1,  0, 1, '0,    1, 1, 3'd1, 1, C_D4, 0);
    vecs[18] = mk(1,  0, 1, '0,    1, 0, 3'd0, 0, '0,   0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk_status("in reset", 1, 0, 3'd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_status("after reset", 1, 0, 3'd0, 0);
    in_valid = 1'b1; #1;
    check("core_issue when ready", 128'(core_issue), 128'(1'b1));
    in_valid = 1'b0; #1;
    check("core_issue idle", 128'(core_issue), 128'(1'b0));

    for (int i = 0; i < 19; i++) begin
      in_valid     = vecs[i].iv;
      out_ready    = vecs[i].ordy;
      core_out_tbl = vecs[i].cd;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk_status($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                 vecs[i].e_occ, vecs[i].e_ovf);
      if (vecs[i].chk_d) check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_d);
      if (i == 4) begin
        in_valid = 1'b1; #1;
        check("core_issue when full", 128'(core_issue), 128'(1'b0));
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; core_out_tbl = '0;

    // ---------------- 50-block stream ----------------
    // Credit limit gives groups of 4 issues every 23 edges.
    stream_mode = 1'b1;
    out_ready   = 1'b1;
    c0 = cyc; issued = 0; popped = 0;
    for (int t = 0; t < 800; t++) begin
      in_valid   = (issued < 50);
      will_issue = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("stream blk%0d", popped), out_data,
              f(c0 + (popped / 4) * 23 + (popped % 4) + LATENCY));
        popped++;
      end
      @(posedge clk); #1;
      if (will_issue) issued++;
      if (popped == 50) break;
    end
    in_valid = 1'b0; out_ready = 1'b0; stream_mode = 1'b0;
    check("stream block count", 128'(popped), 128'(50));
    chk_status("stream end", 1, 0, 3'd0, 0);

    // ---------------- reset mid-operation ----------------
    core_out_tbl = C_BAD;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_status("pre-reset two in flight", 1, 0, 3'd2, 0);
    rst_n = 1'b0; #1;
    chk_status("async reset", 1, 0, 3'd0, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (out_valid || occupancy != 3'd0) seen++;
    end
    check("no capture after reset", 128'(seen), 128'(0));

    // ---------------- forced overflow ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (4) @(posedge clk);
    #1; in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1; core_out_tbl = C_D0; @(posedge clk);
    #1; core_out_tbl = C_D1; @(posedge clk);
    #1; core_out_tbl = C_D2; @(posedge clk);
    #1; core_out_tbl = C_D3; @(posedge clk);
    #1; core_out_tbl = C_BAD;
    chk_status("ovf pre full", 0, 1, 3'd4, 0);
    force dut.capture = 1'b1;
    @(posedge clk); #1;
    release dut.capture;
    #1;
    chk_status("ovf set", 0, 1, 3'd4, 1);
    check("ovf head unchanged", out_data, C_D0);
    repeat (3) @(posedge clk); #1;
    chk_status("ovf sticky", 0, 1, 3'd4, 1);
    out_ready = 1'b1;
    check("ovf drain 0", out_data, C_D0); @(posedge clk); #1;
    check("ovf drain 1", out_data, C_D1); @(posedge clk); #1;
    check("ovf drain 2", out_data, C_D2); @(posedge clk); #1;
    check("ovf drain 3", out_data, C_D3); @(posedge clk); #1;
    out_ready = 1'b0;
    chk_status("ovf drained", 1, 0, 3'd0, 1);
    do_reset();
    #1;
    chk_status("ovf cleared by reset", 1, 0, 3'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
